gate_deadtime: RTL and testbench
================================

Name: gate_deadtime

Overview:
- Converts the regularized switching decision sigma from the regularization stage into complementary high-side/low-side gate commands for one half-bridge leg of the resonant converter.
- Inserts a programmable dead interval (both gates low) at every transition.
- Gates the outputs with an enable and a latched fault shutdown.
- Sits directly downstream of the regularization stage and upstream of the gate-driver pins.

Parameters:
- DT_WIDTH, 8, width of the dead_time input and the internal dead counter.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_signal  input  1  regularized sigma; 1 requests high-side on, 0 requests low-side on
- i_enable  input  1  1 = bridge allowed to switch; 0 = both gates off
- i_fault  input  1  external fault (overcurrent/overvoltage); active high
- i_fault_clear  input  1  single-cycle request to leave FAULT
- dead_time  input  DT_WIDTH  dead interval in clock cycles; 0 is treated as 1
- o_gate_H  output  1  high-side gate command, registered
- o_gate_L  output  1  low-side gate command, registered
- o_fault_latched  output  1  1 while in FAULT
- o_state  output  3  current state encoding, for debug

Behaviour:
- States and encoding: OFF=0, DEAD_TO_H=1, H_ON=2, DEAD_TO_L=3, L_ON=4, FAULT=5. Codes 6 and 7 recover to OFF on the next edge.
- Gate outputs are registered and decoded from the next state, so they change on the same edge as the state.
  - o_gate_H=1 only in H_ON.
  - o_gate_L=1 only in L_ON.
  - Never both 1 in any cycle.
- Reset: state OFF, o_gate_H=0, o_gate_L=0, o_fault_latched=0, dead counter=0. Reset overrides every other input.
- Priority each edge: reset > i_fault > !i_enable > normal transitions.
- i_fault=1 in any state: next state FAULT, both gates 0, o_fault_latched=1.
- FAULT: stays latched even after i_fault drops. Leaves to OFF only on an edge where i_fault_clear=1 and i_fault=0.
- i_enable=0 in any non-FAULT state: next state OFF, both gates 0.
- OFF with i_enable=1 and i_fault=0: goes to DEAD_TO_H if i_signal=1, else DEAD_TO_L.
- Entering either DEAD state: the counter loads max(dead_time,1). dead_time is sampled only at entry; later changes do not affect the current interval.
- In a DEAD state:
  - counter==1: go to the matching ON state.
  - otherwise: decrement the counter.
  - Result: both gates are low for exactly max(dead_time,1) cycles.
- i_signal reverses during DEAD_TO_H (or DEAD_TO_L): switch to the opposite DEAD state and reload the counter. The full dead interval restarts.
- H_ON: i_signal=0 sampled -> DEAD_TO_L, and o_gate_H falls on that same edge.
- L_ON: i_signal=1 sampled -> DEAD_TO_H.
- Latency: an i_signal change sampled at edge k turns the active gate off at edge k. The opposite gate rises at edge k+max(dead_time,1).
- o_state mirrors the state register.

Optional Feature:
- Macro: GATE_PERIOD_MEAS_EN.
- When defined, adds two ports:
  - o_period, output, 32 bits.
  - o_period_valid, output, 1 bit.
- A 32-bit free counter increments every cycle and restarts at 1 on each entry into H_ON.
- On each H_ON entry after the first since reset/OFF/FAULT:
  - o_period <= counter value, i.e. cycles between successive H_ON entries.
  - o_period_valid pulses high for exactly 1 cycle.
- The counter saturates at 0xFFFFFFFF; it does not wrap.
- Leaving to OFF or FAULT clears the first-entry flag. Both outputs reset to 0.
- When undefined: ports and logic are absent. Gate behaviour is identical either way.

Test Plan:
- Reset, then i_enable=1, i_signal=1, dead_time=5 -> both gates 0 for 5 cycles, then o_gate_H=1; o_state sequence 0,1,...,1,2.
- From H_ON with dead_time=3, drop i_signal at edge k -> o_gate_H=0 at k, o_gate_L=1 at k+3; no cycle with both gates high.
- dead_time=0 -> dead interval of exactly 1 cycle on both transitions.
- In DEAD_TO_L (dead_time=10), raise i_signal after 4 cycles -> enter DEAD_TO_H and count a fresh 10 cycles before o_gate_H=1.
- Assert i_fault 1 cycle during L_ON -> gates 0 next edge, o_fault_latched=1. i_fault_clear while i_fault=1 is ignored. i_fault_clear with i_fault=0 -> OFF, then the normal restart sequence.
- GATE_PERIOD_MEAS_EN: square-wave i_signal with 100-cycle period, dead_time=4 -> o_period=100 with a 1-cycle o_period_valid pulse every period from the second H_ON entry on. Deassert i_enable -> no pulse on the first H_ON entry after re-enable.

Source files
------------

// File: rtl/gate_deadtime.sv
// Half-bridge gate sequencer: complementary H/L gate commands with programmable dead time,
// enable gating and latched fault shutdown. Define GATE_PERIOD_MEAS_EN for H_ON period measurement.
module gate_deadtime #(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_signal,
    input  logic                i_enable,
    input  logic                i_fault,
    input  logic                i_fault_clear,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                o_gate_H,
    output logic                o_gate_L,
    output logic                o_fault_latched,
    output logic [2:0]          o_state
`ifdef GATE_PERIOD_MEAS_EN
    ,
    output logic [31:0]         o_period,
    output logic                o_period_valid
`endif
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        DEAD_TO_H = 3'd1,
        H_ON      = 3'd2,
        DEAD_TO_L = 3'd3,
        L_ON      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [DT_WIDTH-1:0] cnt, cnt_next;
    logic [DT_WIDTH-1:0] dt_load;

    assign dt_load = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (i_fault) begin
            state_next = FAULT;
        end else if (state == FAULT) begin
            if (i_fault_clear) state_next = OFF;
        end else if (!i_enable) begin
            state_next = OFF;
        end else begin
            case (state)
                OFF: begin
                    state_next = i_signal ? DEAD_TO_H : DEAD_TO_L;
                    cnt_next   = dt_load;
                end
                DEAD_TO_H: begin
                    // A reversal restarts the full dead interval toward the other side
                    if (!i_signal) begin
                        state_next = DEAD_TO_L;
                        cnt_next   = dt_load;
                    end else if (cnt == DT_WIDTH'(1)) begin
                        state_next = H_ON;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                DEAD_TO_L: begin
                    if (i_signal) begin
                        state_next = DEAD_TO_H;
                        cnt_next   = dt_load;
                    end else if (cnt == DT_WIDTH'(1)) begin
                        state_next = L_ON;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                H_ON: begin
                    if (!i_signal) begin
                        state_next = DEAD_TO_L;
                        cnt_next   = dt_load;
                    end
                end
                L_ON: begin
                    if (i_signal) begin
                        state_next = DEAD_TO_H;
                        cnt_next   = dt_load;
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // Gates decode next state so they switch on the same edge as the state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= OFF;
            cnt      <= '0;
            o_gate_H <= 1'b0;
            o_gate_L <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            o_gate_H <= (state_next == H_ON);
            o_gate_L <= (state_next == L_ON);
        end
    end

    assign o_fault_latched = (state == FAULT);
    assign o_state         = state;

`ifdef GATE_PERIOD_MEAS_EN
    logic [31:0] per_cnt;
    logic        per_seen;
    logic        h_entry;

    assign h_entry = (state_next == H_ON) && (state != H_ON);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            per_cnt        <= '0;
            per_seen       <= 1'b0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
        end else begin
            o_period_valid <= 1'b0;
            if (h_entry) begin
                per_cnt <= 32'd1;
                if (per_seen) begin
                    o_period       <= per_cnt;
                    o_period_valid <= 1'b1;
                end
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + 32'd1;
            end
            if (state_next == OFF || state_next == FAULT) per_seen <= 1'b0;
            else if (h_entry)                              per_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_deadtime.sv
// Bench for gate_deadtime: directed and random stimulus checked every cycle against
// an interval-based reference model (side, elapsed dead cycles, fault latch).
module tb_gate_deadtime;

    logic       i_clk = 1'b0;
    logic       i_reset, i_signal, i_enable, i_fault, i_fault_clear;
    logic [7:0] dead_time;
    logic       o_gate_H, o_gate_L, o_fault_latched;
    logic [2:0] o_state;
`ifdef GATE_PERIOD_MEAS_EN
    logic [31:0] o_period;
    logic        o_period_valid;
`endif

    int tests = 0;
    int fails = 0;

    gate_deadtime #(.DT_WIDTH(8)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_signal       (i_signal),
        .i_enable       (i_enable),
        .i_fault        (i_fault),
        .i_fault_clear  (i_fault_clear),
        .dead_time      (dead_time),
        .o_gate_H       (o_gate_H),
        .o_gate_L       (o_gate_L),
        .o_fault_latched(o_fault_latched),
        .o_state        (o_state)
`ifdef GATE_PERIOD_MEAS_EN
        ,
        .o_period       (o_period),
        .o_period_valid (o_period_valid)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference model: which side is targeted, whether it has been reached,
    // how many dead cycles have elapsed and how long this interval must be.
    bit m_fault, m_active, m_side, m_on;
    int m_elapsed, m_len;
    longint m_pcnt;
    bit     m_pseen, m_pvalid;
    logic [31:0] m_period;

    function automatic int exp_state();
        if (m_fault)   return 5;
        if (!m_active) return 0;
        if (m_on)      return m_side ? 2 : 4;
        return m_side ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic s, e, f, c, input logic [7:0] d, input logic r);
        int prev;
        prev = exp_state();
        if (r) begin
            m_fault = 0; m_active = 0; m_on = 0; m_side = 0; m_elapsed = 0; m_len = 1;
            m_pcnt = 0; m_pseen = 0; m_pvalid = 0; m_period = 0;
            return;
        end
        if (f) begin
            m_fault = 1; m_active = 0;
        end else if (m_fault) begin
            if (c) m_fault = 0;
        end else if (!e) begin
            m_active = 0;
        end else if (!m_active || s != m_side) begin
            m_active = 1; m_side = s; m_on = 0; m_elapsed = 0;
            m_len = (d == 0) ? 1 : int'(d);
        end else if (!m_on) begin
            m_elapsed++;
            if (m_elapsed == m_len) m_on = 1;
        end
        m_pvalid = 0;
        if (exp_state() == 2 && prev != 2) begin
            if (m_pseen) begin
                m_period = m_pcnt[31:0];
                m_pvalid = 1;
            end
            m_pcnt  = 1;
            m_pseen = 1;
        end else if (m_pcnt < 64'hFFFF_FFFF) begin
            m_pcnt++;
        end
        if (exp_state() == 0 || exp_state() == 5) m_pseen = 0;
    endtask

    task automatic step(input logic s, e, f, c, input logic [7:0] d, input logic r);
        int es;
        i_signal = s; i_enable = e; i_fault = f; i_fault_clear = c; dead_time = d; i_reset = r;
        @(posedge i_clk);
        model(s, e, f, c, d, r);
        #1;
        es = exp_state();
        chk("state", 32'(o_state), 32'(es));
        chk("gate_H", 32'(o_gate_H), 32'(es == 2));
        chk("gate_L", 32'(o_gate_L), 32'(es == 4));
        chk("fault_latched", 32'(o_fault_latched), 32'(m_fault));
        chk("no_shoot_through", 32'(o_gate_H & o_gate_L), 32'(0));
`ifdef GATE_PERIOD_MEAS_EN
        chk("period_valid", 32'(o_period_valid), 32'(m_pvalid));
        chk("period", o_period, m_period);
`endif
    endtask

    task automatic run(input int n, input logic s, e, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(s, e, 1'b0, 1'b0, d, 1'b0);
    endtask

    initial begin
        logic s, e, f, c, r;
        logic [7:0] d;

        // Reset held, then release with signal high and dead time 5
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1);
        run(8, 1'b1, 1'b1, 8'd5);

        // Falling request with dead time 3
        run(6, 1'b0, 1'b1, 8'd3);

        // Zero dead time behaves as one cycle both ways
        run(3, 1'b1, 1'b1, 8'd0);
        run(3, 1'b0, 1'b1, 8'd0);

        // Reversal mid dead interval restarts a fresh count
        run(12, 1'b1, 1'b1, 8'd10);
        run(4, 1'b0, 1'b1, 8'd10);
        run(12, 1'b1, 1'b1, 8'd10);

        // Fault during L_ON, ignored clear, then valid clear and restart
        run(5, 1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
        run(2, 1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0);
        run(5, 1'b1, 1'b1, 8'd2);

        // 100-cycle square wave, then enable drop and restart
        for (int p = 0; p < 4; p++) begin
            run(50, 1'b1, 1'b1, 8'd4);
            run(50, 1'b0, 1'b1, 8'd4);
        end
        run(5, 1'b0, 1'b0, 8'd4);
        for (int p = 0; p < 2; p++) begin
            run(50, 1'b1, 1'b1, 8'd4);
            run(50, 1'b0, 1'b1, 8'd4);
        end

        // Randomized traffic
        s = 1'b0; d = 8'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)  s = ~s;
            if ($urandom_range(31) == 0) d = 8'($urandom_range(7));
            e = ($urandom_range(63) != 0);
            f = ($urandom_range(99) == 0);
            c = ($urandom_range(3) == 0);
            r = ($urandom_range(499) == 0);
            step(s, e, f, c, d, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
